// File: rtl/icache_assoc_pkg.sv
// Shared types and address-split helpers for the set-associative instruction cache.
// Address layout, low to high: byte offset [1:0], word-in-block offset,
// set index, then tag.
package icache_assoc_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

    localparam int unsigned BYTE_BITS = 2;

    // Word offset within a block (always 0 for one-word blocks)
    function automatic word_t addr_word_off(input word_t a, input int unsigned bw);
        return (a >> BYTE_BITS) & word_t'(bw - 1);
    endfunction

    // Set index field
    function automatic word_t addr_index(input word_t a, input int unsigned sets,
                                         input int unsigned bw);
        return (a >> (BYTE_BITS + $clog2(bw))) & word_t'(sets - 1);
    endfunction

    // Tag field: everything above the index
    function automatic word_t addr_tag(input word_t a, input int unsigned sets,
                                       input int unsigned bw);
        return a >> (BYTE_BITS + $clog2(bw) + $clog2(sets));
    endfunction

    // Block base address: byte and word offsets zeroed
    function automatic word_t block_base(input word_t a, input int unsigned bw);
        return a & ~word_t'(bw * 4 - 1);
    endfunction

endpackage

// File: rtl/icache_assoc_if.sv
// Fetch-side and memory-side signals of the instruction cache.
// slave: the cache itself; master: the datapath/memory environment driving it.
interface icache_assoc_if;
    import icache_assoc_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    word_t imemload;
    logic  ihit;
    logic  iflush;
    logic  iREN;
    word_t iaddr;
    word_t iload;
    logic  iwait;

    modport slave (
        input  imemREN, imemaddr, iflush, iload, iwait,
        output imemload, ihit, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iflush, iload, iwait,
        input  imemload, ihit, iREN, iaddr
    );
endinterface

// File: rtl/icache_way.sv
// One way of the instruction cache: valid bits, tag array and block data.
// Lookup is combinational; writes land on the rising edge. Only the valid
// bits are reset or flushed; tags and data keep stale contents.
module icache_way
    import icache_assoc_pkg::*;
#(
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 2,
    parameter int IDX_W       = 3,
    parameter int OFF_W       = 1,
    parameter int TAG_W       = 26
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [OFF_W-1:0] rd_off,
    input  logic [TAG_W-1:0] rd_tag,
    output logic             hit,
    output logic             valid,
    output word_t            rd_word,
    input  logic             wr_word_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [OFF_W-1:0] wr_off,
    input  word_t            wr_word,
    input  logic             wr_tag_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic             flush
);

    localparam int DEPTH  = SETS * BLOCK_WORDS;
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [SETS-1:0]  valid_reg;
    logic [TAG_W-1:0] tag_mem  [SETS];
    word_t            data_mem [DEPTH];

    // Flat data slot for a (set, word) pair
    function automatic logic [ADDR_W-1:0] slot(input logic [IDX_W-1:0] idx,
                                               input logic [OFF_W-1:0] off);
        return ADDR_W'(int'(idx) * BLOCK_WORDS + int'(off));
    endfunction

    assign valid   = valid_reg[rd_idx];
    assign hit     = valid && (tag_mem[rd_idx] == rd_tag);
    assign rd_word = data_mem[slot(rd_idx, rd_off)];

    // Valid bits: cleared by reset or flush, set when a block's last word lands
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_reg <= '0;
        end else if (flush) begin
            valid_reg <= '0;
        end else if (wr_tag_en) begin
            valid_reg[wr_idx] <= 1'b1;
        end
    end

    // Tag and data storage, never reset
    always_ff @(posedge CLK) begin
        if (wr_tag_en) begin
            tag_mem[wr_idx] <= wr_tag;
        end
        if (wr_word_en) begin
            data_mem[slot(wr_idx, wr_off)] <= wr_word;
        end
    end

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache (1 or 2 ways, LRU, multi-word burst refill,
// whole-cache flush). Optional hit/miss counters are enabled by defining
// ICACHE_STATS_EN, which adds the hit_count/miss_count outputs.
module icache_assoc
    import icache_assoc_pkg::*;
#(
    parameter int WAYS        = 2,
    parameter int SETS        = 8,
    parameter int BLOCK_WORDS = 2
) (
    input  logic CLK,
    input  logic RST,
    icache_assoc_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);

    localparam int OFF_W = $clog2(BLOCK_WORDS);
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - int'(BYTE_BITS) - OFF_W - IDX_W;
    localparam int CNT_W = (BLOCK_WORDS > 1) ? OFF_W : 1;

    icache_state_t    state_reg;
    logic [CNT_W-1:0] cnt_reg;
    word_t            base_reg;
    logic             victim_reg;
    logic             iren_reg;
    word_t            iaddr_reg;

    logic [IDX_W-1:0] req_idx, fill_idx;
    logic [CNT_W-1:0] req_off;
    logic [TAG_W-1:0] req_tag, fill_tag;
    logic [WAYS-1:0]  way_hit, way_valid, way_wr_word, way_wr_tag;
    word_t            way_word [WAYS];
    logic             lookup_hit, miss_start, hit_way, lru_victim, victim_next;
    logic             fill_fire, fill_last;

    assign req_idx  = IDX_W'(addr_index(bus.imemaddr, SETS, BLOCK_WORDS));
    assign req_off  = CNT_W'(addr_word_off(bus.imemaddr, BLOCK_WORDS));
    assign req_tag  = TAG_W'(addr_tag(bus.imemaddr, SETS, BLOCK_WORDS));
    assign fill_idx = IDX_W'(addr_index(base_reg, SETS, BLOCK_WORDS));
    assign fill_tag = TAG_W'(addr_tag(base_reg, SETS, BLOCK_WORDS));

    // Flush and reset both suppress the lookup for the current cycle
    assign lookup_hit = (state_reg == IDLE) && bus.imemREN && !bus.iflush && !RST && (|way_hit);
    assign miss_start = (state_reg == IDLE) && bus.imemREN && !bus.iflush && !RST && !(|way_hit);
    assign hit_way    = (WAYS == 2) ? way_hit[WAYS-1] : 1'b0;

    assign fill_fire = (state_reg == FILL) && !bus.iwait && !bus.iflush && !RST;
    assign fill_last = fill_fire && (cnt_reg == CNT_W'(BLOCK_WORDS - 1));

    assign bus.ihit     = lookup_hit;
    assign bus.imemload = !lookup_hit ? '0 : (hit_way ? way_word[WAYS-1] : way_word[0]);
    assign bus.iREN     = iren_reg;
    assign bus.iaddr    = iaddr_reg;

    // Victim choice: lowest invalid way first, otherwise the LRU way
    always_comb begin
        victim_next = 1'b0;
        if (WAYS == 2) begin
            if (!way_valid[0]) begin
                victim_next = 1'b0;
            end else if (!way_valid[WAYS-1]) begin
                victim_next = 1'b1;
            end else begin
                victim_next = lru_victim;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < WAYS; gi++) begin : g_way
            assign way_wr_word[gi] = fill_fire && (victim_reg == 1'(gi));
            assign way_wr_tag[gi]  = fill_last && (victim_reg == 1'(gi));

            icache_way #(
                .SETS        (SETS),
                .BLOCK_WORDS (BLOCK_WORDS),
                .IDX_W       (IDX_W),
                .OFF_W       (CNT_W),
                .TAG_W       (TAG_W)
            ) u_way (
                .CLK        (CLK),
                .RST        (RST),
                .rd_idx     (req_idx),
                .rd_off     (req_off),
                .rd_tag     (req_tag),
                .hit        (way_hit[gi]),
                .valid      (way_valid[gi]),
                .rd_word    (way_word[gi]),
                .wr_word_en (way_wr_word[gi]),
                .wr_idx     (fill_idx),
                .wr_off     (cnt_reg),
                .wr_word    (bus.iload),
                .wr_tag_en  (way_wr_tag[gi]),
                .wr_tag     (fill_tag),
                .flush      (bus.iflush)
            );
        end

        if (WAYS == 2) begin : g_lru
            logic [SETS-1:0] lru_reg;

            assign lru_victim = lru_reg[req_idx];

            // LRU bit points at the way to evict next: the one not just used
            always_ff @(posedge CLK) begin
                if (RST) begin
                    lru_reg <= '0;
                end else if (lookup_hit) begin
                    lru_reg[req_idx] <= ~hit_way;
                end else if (fill_last) begin
                    lru_reg[fill_idx] <= ~victim_reg;
                end
            end
        end else begin : g_no_lru
            assign lru_victim = 1'b0;
        end
    endgenerate

    // Miss/refill FSM with registered memory request and address
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            base_reg   <= '0;
            victim_reg <= 1'b0;
            iren_reg   <= 1'b0;
            iaddr_reg  <= '0;
        end else if (bus.iflush) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            iren_reg  <= 1'b0;
            iaddr_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (miss_start) begin
                        state_reg  <= FILL;
                        cnt_reg    <= '0;
                        base_reg   <= block_base(bus.imemaddr, BLOCK_WORDS);
                        victim_reg <= victim_next;
                        iren_reg   <= 1'b1;
                        iaddr_reg  <= block_base(bus.imemaddr, BLOCK_WORDS);
                    end
                end
                FILL: begin
                    if (!bus.iwait) begin
                        if (cnt_reg == CNT_W'(BLOCK_WORDS - 1)) begin
                            state_reg <= IDLE;
                            cnt_reg   <= '0;
                            iren_reg  <= 1'b0;
                            iaddr_reg <= '0;
                        end else begin
                            cnt_reg   <= cnt_reg + 1'b1;
                            iaddr_reg <= iaddr_reg + 32'd4;
                        end
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count_reg, miss_count_reg;

    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    // Saturating hit/miss counters; flush does not clear them
    always_ff @(posedge CLK) begin
        if (RST) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (lookup_hit && (hit_count_reg != 32'hFFFF_FFFF)) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
            if (miss_start && (miss_count_reg != 32'hFFFF_FFFF)) begin
                miss_count_reg <= miss_count_reg + 32'd1;
            end
        end
    end
`endif

endmodule

// File: doc/icache_assoc.md
Name: icache_assoc

Overview:
Parametrised set-associative instruction cache with multi-word blocks. It is the successor to the direct-mapped, one-word-per-block icache.
Sits between the datapath fetch port and the memory controller instruction port.
Adds associativity (1 or 2 ways), LRU replacement, burst block refill from a latched miss address, and a whole-cache flush.

Parameters:
WAYS, 2, associativity; legal values 1 or 2
SETS, 8, number of sets; power of two, 2..64
BLOCK_WORDS, 2, 32-bit words per block; power of two, 1..8

Ports:
CLK  input  1  clock; all state updates on rising edge
RST  input  1  reset, synchronous, active-high
imemREN  input  1  datapath fetch request
imemaddr  input  32  fetch byte address; bits [1:0] ignored
imemload  output  32  fetched instruction; 0 when ihit=0
ihit  output  1  fetch satisfied this cycle
iflush  input  1  invalidate entire cache
iREN  output  1  memory read request
iaddr  output  32  memory word address; 0 when iREN=0
iload  input  32  memory read data
iwait  input  1  memory busy; data valid when iREN=1 and iwait=0

Behaviour:
- Address split: [1:0] byte, then log2(BLOCK_WORDS) word offset, then log2(SETS) index, remainder tag. With defaults: word=[2], idx=[5:3], tag=[31:6].
- Reset (RST=1 at edge): all valid bits 0, all LRU bits 0, state IDLE, word counter 0. Outputs: ihit=0, imemload=0, iREN=0, iaddr=0.
- Data and tag arrays are not reset.
- States: IDLE, FILL.
- IDLE lookup is combinational in the same cycle:
  - ihit=1 iff imemREN and some way has valid and tag match.
  - imemload = matching word.
  - On a hit with WAYS=2, LRU[idx] is set to the other way at the edge.
- IDLE miss (imemREN=1, no hit, iflush=0):
  - Latch block base address (word offset zeroed) and victim way.
  - Victim = lowest-numbered invalid way, else LRU[idx].
  - Go to FILL with counter=0.
  - ihit=0 in the miss cycle.
- FILL:
  - iREN=1, iaddr = base + 4*counter.
  - On iwait=0: write iload into victim/set/counter and increment counter.
  - On the last word (counter=BLOCK_WORDS-1): write tag, set valid, set LRU to the non-victim way, go to IDLE.
  - ihit stays 0 throughout FILL.
  - The latched address is used for the whole fill; changes to imemaddr or imemREN mid-fill are ignored.
- Post-fill: the first IDLE cycle after the fill hits, given the same imemaddr. Miss latency = 1 + sum of per-word memory wait cycles.
- iflush has priority in any state:
  - Clears all valid bits at the edge and forces ihit=0 in that cycle.
  - During FILL it aborts the fill: no tag or valid is written, state goes to IDLE, and iREN drops the next cycle.
- RST mid-FILL: returns to IDLE and discards partial block data (valid remains 0).
- WAYS=1: LRU logic is absent and the victim is always way 0, giving direct-mapped behaviour.
- Simultaneous flush and request: the flush wins; the request is re-looked-up next cycle and misses.

Optional Feature:
ICACHE_STATS_EN:
- Defined: adds outputs hit_count[31:0] and miss_count[31:0].
  - hit_count increments every cycle ihit=1.
  - miss_count increments on each IDLE->FILL transition.
  - Both saturate at 0xFFFFFFFF, reset to 0, and are not cleared by iflush.
- Undefined: the ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- cpu_types_pkg gets:
  - the icache_state_t enum (IDLE, FILL);
  - a parametrised address-split helper (localparams derived from SETS/BLOCK_WORDS);
  - the word_t reuse.
- Sub-module icache_way: one way's valid/tag/data arrays, with combinational lookup (hit, word out) and write ports (word write, tag+valid write, flush). Instantiated WAYS times by generate.
- FSM, LRU and the memory handshake stay in icache_assoc.

Test Plan:
- Cold miss, defaults, imemaddr=0x40, iwait low for 1 cycle per word (iload 0xAAAA0001, 0xAAAA0002):
  - iaddr 0x40 then 0x44.
  - ihit=1 with imemload=0xAAAA0001.
  - Then addr 0x44 hits with 0xAAAA0002 and no iREN.
- Two-way conflict: fill 0x00, fill 0x40, hit 0x00, then miss 0x80:
  - 0x40's way is evicted.
  - 0x00 still hits; 0x40 misses.
- WAYS=1 SETS=16 BLOCK_WORDS=1:
  - 0x00 and 0x40 alternate: each access misses.
  - iaddr equals the request address.
- Flush during FILL after the first word of 0x40:
  - iREN drops the next cycle.
  - A later 0x40 access misses and refills both words.
- imemaddr changed to 0x100 mid-fill of 0x40:
  - The fill completes at 0x40/0x44 before 0x100 is looked up.
- With ICACHE_STATS_EN, 1 miss then 3 hit cycles:
  - miss_count=1, hit_count=3 (including the post-fill hit).
  - iflush leaves both counts unchanged.
